inst_rom_loader: RTL
====================

# inst_rom_loader

Instruction-memory responder for the pipeline's fetch port. It answers the core's `rom_enable`/`rom_addr_out` requests with `rom_data_in` words and owns a byte-stream loader FSM that writes a program image into the array. While a load is in progress it holds the core in reset. It sits at top level beside the core, between a host byte source (UART/JTAG bridge) and the core's instruction port.

## Interface
- `DEPTH_LOG2`, 10: log2 of word count (1024 words).
- `BOOT_HOLD`, 1: 1 = core held in reset after reset until the first successful load; 0 = core released immediately (preinitialised image).
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset is synchronous and active-low (sampled on rising `clk` only).
- `ce` input 1: fetch enable, from core `rom_enable`.
- `addr` input `INST_ADDR_WIDTH`: byte address from core `rom_addr_out`.
- `inst` output `INST_DATA_WIDTH`: instruction word to core `rom_data_in`.
- `ld_start` input 1: one-cycle pulse that begins a load.
- `ld_valid` input 1: `ld_data` valid.
- `ld_data` input 8: image byte, big-endian within a word.
- `ld_last` input 1: qualifies the final byte of the image.
- `ld_ready` output 1: loader accepts a byte this cycle.
- `ld_done` output 1: one-cycle pulse, load completed cleanly.
- `ld_err` output 1: sticky error, cleared by the next `ld_start` or reset.
- `word_count` output `DEPTH_LOG2+1`: words written by the current/last load.
- `core_rst_n` output 1: active-low reset to the core.

## Operation
- Word index is `addr[DEPTH_LOG2+1:2]`. `addr[1:0]` and bits above the index are ignored, so addresses wrap modulo the depth.
- Fetch read is combinational. `inst = mem[index]` when `ce=1` and state is RUN; otherwise `inst = 0` (a MIPS nop).
- FSM states:
  - HOLD: post-reset state when `BOOT_HOLD=1`.
  - LOAD: collecting bytes.
  - FLUSH: one cycle.
  - RUN: post-reset state when `BOOT_HOLD=0`.
- `ld_start` in any state: go to LOAD and clear the byte counter, `word_count` and `ld_err`.
- In LOAD, `ld_ready=1`. A byte transfers when `ld_valid & ld_ready`.
- Bytes shift into a 32-bit assembler, first byte lands in [31:24]. On the 4th byte the word is written to `mem[word_count]` and `word_count` increments.
- Transfer with `ld_last=1` on a word boundary (4th byte): go to FLUSH.
- Transfer with `ld_last=1` off a word boundary: pad the remaining low bytes with 0, write the word, set `ld_err`, go to FLUSH.
- A write attempt with `word_count == 2**DEPTH_LOG2`: the write is dropped, `ld_err` is set, the FSM stays in LOAD, and bytes keep being drained until `ld_last`.
- FLUSH: emit a one-cycle `ld_done` pulse only if `ld_err=0`, then go to RUN. After an error the FSM goes to HOLD instead.
- `core_rst_n=1` only in RUN.

## Timing
- Reset values:
  - state: HOLD (or RUN if `BOOT_HOLD=0`)
  - `ld_ready=0`, `ld_done=0`, `ld_err=0`, `word_count=0`
  - `core_rst_n=0` (1 if `BOOT_HOLD=0`)
  - memory contents are not reset.
- `ld_ready` and `core_rst_n` are registered functions of state. `ld_ready` rises the cycle after `ld_start`.
- Memory write occurs on the edge that accepts the 4th byte. `word_count` updates on the same edge.
- `ld_last` accepted at edge N: FLUSH during N+1 with `ld_done` high, RUN from N+2, and `core_rst_n` high from N+2. The core's first fetch sees the new image.
- `ld_start` coinciding with a byte transfer: `ld_start` wins and the byte is discarded.
- `ld_start` during RUN: `core_rst_n` falls on the next edge, and no partially written image is ever fetched.
- `rst_n` low during LOAD: abort, partial writes remain in memory, return to the reset state.
- `ld_valid` with `ld_ready=0` is ignored; no buffering.

## Structure
- Shared defines header: `INST_ADDR_WIDTH`, `INST_DATA_WIDTH`, and the FSM state encodings `LD_HOLD`/`LD_LOAD`/`LD_FLUSH`/`LD_RUN`.
- One natural sub-module: `inst_ram`, a synchronous-write / asynchronous-read word array parameterised by `DEPTH_LOG2`.
- The FSM, byte assembler and counters stay in `inst_rom_loader`.

## Test plan
- Reset with `BOOT_HOLD=1`, then `ce=1`, `addr=0`: `inst=0`, `core_rst_n=0`, `ld_ready=0`.
- `ld_start`, then bytes 34 01 00 05 | 34 02 00 07 with `ld_last` on the 8th byte:
  - `word_count=2`, one `ld_done` pulse, `core_rst_n` rises 2 cycles after the last byte.
  - `addr=0` gives `inst=32'h34010005`; `addr=4` gives `32'h34020007`.
- Fetch check: `addr=32'h00001004` with `DEPTH_LOG2=10` returns word 1 (wrap); `ce=0` returns 0.
- 6-byte image with `ld_last` on byte 6: word 1 = `32'hAABB0000` padded, `ld_err=1`, no `ld_done`, FSM in HOLD.
- Overflow with `DEPTH_LOG2=2`: 5-word image gives `word_count=4`, `ld_err=1`, word 0 not overwritten.
- `ld_start` mid-RUN, then `rst_n` low mid-LOAD:
  - `core_rst_n` falls next cycle.
  - After reset, all outputs hold their reset values.

Source files
------------

// File: rtl/inst_rom_loader_pkg.sv
// inst_rom_loader_pkg: shared widths, loader state encodings and byte-placement helper
package inst_rom_loader_pkg;
  localparam int INST_ADDR_WIDTH = 32;
  localparam int INST_DATA_WIDTH = 32;
  typedef enum logic [1:0] {
    LD_HOLD  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_FLUSH = 2'd2,
    LD_RUN   = 2'd3
  } ld_state_e;
  function automatic logic [31:0] place_byte(input logic [31:0] w, input logic [7:0] b, input logic [1:0] idx);
    return w | ({b, 24'h0} >> {idx, 3'b000});
  endfunction
endpackage

// File: rtl/inst_rom_loader_ram.sv
// inst_ram: synchronous-write, asynchronous-read word array
module inst_ram #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);
  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  // word write; contents are deliberately never reset
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: fetch responder with a byte-stream image loader that holds the core in reset while loading
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter bit BOOT_HOLD  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ce,
  input  logic [INST_ADDR_WIDTH-1:0] addr,
  output logic [INST_DATA_WIDTH-1:0] inst,
  input  logic                       ld_start,
  input  logic                       ld_valid,
  input  logic [7:0]                 ld_data,
  input  logic                       ld_last,
  output logic                       ld_ready,
  output logic                       ld_done,
  output logic                       ld_err,
  output logic [DEPTH_LOG2:0]        word_count,
  output logic                       core_rst_n
);
  localparam ld_state_e RST_STATE = BOOT_HOLD ? LD_HOLD : LD_RUN;
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  ld_state_e state_q, state_d;
  logic [31:0] asm_q, asm_d, word, rdata;
  logic [1:0] bcnt_q, bcnt_d;
  logic [DEPTH_LOG2:0] wc_q, wc_d;
  logic err_q, err_d, ready_q, done_q, crst_q;
  logic xfer, word_end, full, we;
  logic unused_addr;
  assign unused_addr = ^{addr[INST_ADDR_WIDTH-1:DEPTH_LOG2+2], addr[1:0]};
  assign xfer     = ld_valid & ready_q;
  assign word     = place_byte(asm_q, ld_data, bcnt_q);
  assign word_end = xfer & (bcnt_q == 2'd3 | ld_last);
  assign full     = wc_q == FULL;
  assign we       = word_end & ~full & ~ld_start;
  // next state: ld_start overrides everything, including a coincident byte
  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    bcnt_d  = bcnt_q;
    wc_d    = wc_q;
    err_d   = err_q;
    if (ld_start) begin
      state_d = LD_LOAD;
      asm_d   = '0;
      bcnt_d  = '0;
      wc_d    = '0;
      err_d   = 1'b0;
    end else if (state_q == LD_LOAD && xfer) begin
      asm_d  = word_end ? '0 : word;
      bcnt_d = word_end ? 2'd0 : bcnt_q + 2'd1;
      wc_d   = we ? wc_q + 1'b1 : wc_q;
      err_d  = err_q | (word_end & full) | (ld_last & bcnt_q != 2'd3);
      state_d = ld_last ? LD_FLUSH : LD_LOAD;
    end else if (state_q == LD_FLUSH)
      state_d = err_q ? LD_HOLD : LD_RUN;
  end
  // state and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      asm_q   <= '0;
      bcnt_q  <= '0;
      wc_q    <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      crst_q  <= !BOOT_HOLD;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      bcnt_q  <= bcnt_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
      ready_q <= state_d == LD_LOAD;
      done_q  <= state_d == LD_FLUSH && !err_d;
      crst_q  <= state_d == LD_RUN;
    end
  end
  inst_ram #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(INST_DATA_WIDTH)) u_ram (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(wc_q[DEPTH_LOG2-1:0]),
    .wdata_i(word),
    .raddr_i(addr[DEPTH_LOG2+1:2]),
    .rdata_o(rdata)
  );
  assign inst       = (ce && state_q == LD_RUN) ? rdata : '0;
  assign ld_ready   = ready_q;
  assign ld_done    = done_q;
  assign ld_err     = err_q;
  assign word_count = wc_q;
  assign core_rst_n = crst_q;
endmodule
